muldiv_ctrl: RTL and testbench

Sequencing controller for the EX-stage multiply/divide resources. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EX, drives the pipelined multiplier and the iterative divider, owns the HI/LO registers, and raises the EX stall request while a long operation is in flight. Sits beside the ALU inside EX; its stall request feeds the pipeline stall controller.

---
 rtl/muldiv_ctrl_pkg.sv | 24 ++
 rtl/muldiv_ctrl_hilo_reg.sv | 31 +++
 rtl/muldiv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op/state encodings for the EX-stage multiply/divide controller.
// Optional build macro DIV_ZERO_FAST_EN (used in muldiv_ctrl) short-circuits divide-by-zero.
package muldiv_ctrl_pkg;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_RUN  = 2'd2,
        S_DONE     = 2'd3
    } state_e;
    localparam int CNT_W = 4;
    function automatic logic is_long(input op_e o);
        return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction
endpackage

// File: rtl/muldiv_ctrl_hilo_reg.sv
// muldiv_ctrl_hilo_reg: HI/LO register pair with independent write enables.
// Ports: clk, rst (sync, active-high); flush suppresses any write this cycle;
// hi_we/lo_we with hi_wd/lo_wd write data; hi/lo registered outputs.
module muldiv_ctrl_hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_wd,
    input  logic [31:0] lo_wd,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    always_comb begin
        hi_d = (hi_we && !flush) ? hi_wd : hi_q;
        lo_d = (lo_we && !flush) ? lo_wd : lo_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the pipelined multiplier, iterative divider and HI/LO.
// Ports: clk, rst (sync, active-high); op_valid/op/opa/opb from EX; flush aborts;
// stallreq (combinational) to the stall controller; hi/lo registered HI/LO;
// mul_signed/mul_ina/mul_inb out, mul_result in (valid MUL_LAT cycles after operands);
// div_start/div_signed/div_opdata1/div_opdata2/div_annul out, div_result {rem,quo}/div_ready in.
// Build macro DIV_ZERO_FAST_EN: divide by zero completes at accept with HI=opa, LO=all ones.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    output logic        stallreq,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
    logic              div_start_q, div_start_d, div_annul_q, div_annul_d;
    logic [31:0]       mul_ina_q, mul_ina_d, mul_inb_q, mul_inb_d;
    logic [31:0]       div_op1_q, div_op1_d, div_op2_q, div_op2_d;
    logic              hi_we, lo_we;
    logic [31:0]       hi_wd, lo_wd;
    op_e               op_c;

    assign op_c = op_e'(op);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_signed_d = mul_signed_q;
        mul_ina_d    = mul_ina_q;
        mul_inb_d    = mul_inb_q;
        div_signed_d = div_signed_q;
        div_op1_d    = div_op1_q;
        div_op2_d    = div_op2_q;
        div_start_d  = div_start_q;
        div_annul_d  = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wd        = opa;
        lo_wd        = opa;
        case (state_q)
            S_IDLE: if (op_valid) begin
                if (op_c == OP_MULT || op_c == OP_MULTU) begin
                    mul_ina_d    = opa;
                    mul_inb_d    = opb;
                    mul_signed_d = (op_c == OP_MULT);
                    cnt_d        = LAT;
                    state_d      = S_MUL_WAIT;
                end else if (op_c == OP_DIV || op_c == OP_DIVU) begin
`ifdef DIV_ZERO_FAST_EN
                    if (opb == '0) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        lo_wd   = '1;
                        state_d = S_DONE;
                    end else begin
                        div_op1_d    = opa;
                        div_op2_d    = opb;
                        div_signed_d = (op_c == OP_DIV);
                        div_start_d  = 1'b1;
                        state_d      = S_DIV_RUN;
                    end
`else
                    div_op1_d    = opa;
                    div_op2_d    = opb;
                    div_signed_d = (op_c == OP_DIV);
                    div_start_d  = 1'b1;
                    state_d      = S_DIV_RUN;
`endif
                end else if (op_c == OP_MTHI) begin
                    hi_we = 1'b1;
                end else if (op_c == OP_MTLO) begin
                    lo_we = 1'b1;
                end
            end
            S_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_wd   = mul_result[63:32];
                    lo_wd   = mul_result[31:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV_RUN: if (div_ready) begin
                hi_we       = 1'b1;
                lo_we       = 1'b1;
                hi_wd       = div_result[63:32];
                lo_wd       = div_result[31:0];
                div_start_d = 1'b0;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything but reset; operands stay as they were and
        // the HI/LO writes are dropped inside hilo_reg.
        if (flush) begin
            state_d      = S_IDLE;
            cnt_d        = cnt_q;
            mul_signed_d = mul_signed_q;
            mul_ina_d    = mul_ina_q;
            mul_inb_d    = mul_inb_q;
            div_signed_d = div_signed_q;
            div_op1_d    = div_op1_q;
            div_op2_d    = div_op2_q;
            div_start_d  = 1'b0;
            div_annul_d  = (state_q == S_DIV_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mul_signed_q <= 1'b0;
            mul_ina_q    <= '0;
            mul_inb_q    <= '0;
            div_signed_q <= 1'b0;
            div_op1_q    <= '0;
            div_op2_q    <= '0;
            div_start_q  <= 1'b0;
            div_annul_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_signed_q <= mul_signed_d;
            mul_ina_q    <= mul_ina_d;
            mul_inb_q    <= mul_inb_d;
            div_signed_q <= div_signed_d;
            div_op1_q    <= div_op1_d;
            div_op2_q    <= div_op2_d;
            div_start_q  <= div_start_d;
            div_annul_q  <= div_annul_d;
        end
    end

    muldiv_ctrl_hilo_reg u_hilo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_wd (hi_wd),
        .lo_wd (lo_wd),
        .hi    (hi),
        .lo    (lo)
    );

    // Gated by rst so an op held on the bus during reset does not stall the pipe.
    assign stallreq = !rst && !flush &&
                      ((state_q == S_IDLE && op_valid && is_long(op_c)) ||
                       state_q == S_MUL_WAIT || state_q == S_DIV_RUN);

    assign mul_signed  = mul_signed_q;
    assign mul_ina     = mul_ina_q;
    assign mul_inb     = mul_inb_q;
    assign div_start   = div_start_q;
    assign div_signed  = div_signed_q;
    assign div_opdata1 = div_op1_q;
    assign div_opdata2 = div_op2_q;
    assign div_annul   = div_annul_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl with multiplier/divider models.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, op_valid, flush;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        stallreq;
    logic [31:0] hi, lo;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .flush       (flush),
        .stallreq    (stallreq),
        .hi          (hi),
        .lo          (lo),
        .mul_signed  (mul_signed),
        .mul_ina     (mul_ina),
        .mul_inb     (mul_inb),
        .mul_result  (mul_result),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_opdata1 (div_opdata1),
        .div_opdata2 (div_opdata2),
        .div_annul   (div_annul),
        .div_result  (div_result),
        .div_ready   (div_ready)
    );

    // Multiplier model: MUL_LAT register stages behind the operand registers.
    logic [63:0] prod;
    logic [63:0] pipe [MUL_LAT];
    assign prod = mul_signed ? $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb})
                             : {32'b0, mul_ina} * {32'b0, mul_inb};
    always_ff @(posedge clk) begin
        pipe[0] <= prod;
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_result = pipe[MUL_LAT-1];

    // Divider model: div_ready after div_start has been high for 32 edges.
    int dcnt;
    always_ff @(posedge clk) begin
        if (!div_start || div_annul) dcnt <= 0;
        else if (dcnt < 32) dcnt <= dcnt + 1;
    end
    assign div_ready = div_start && dcnt == 32;
    always_comb begin
        div_result = '0;
        if (div_opdata2 == '0)
            div_result = {div_opdata1, 32'hFFFFFFFF};
        else if (div_signed)
            div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                          32'($signed(div_opdata1) / $signed(div_opdata2))};
        else
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a long op at posedge+1 and counts stall cycles until DONE.
    task automatic run_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int n, output int ds);
        op_valid = 1'b1;
        op = o;
        opa = a;
        opb = b;
        n = 0;
        ds = 0;
        #1;
        while (stallreq && n < 200) begin
            if (div_start) ds++;
            n++;
            @(posedge clk);
            #2;
        end
    endtask

    int n, ds;

    initial begin
        rst = 1'b1; op_valid = 1'b1; op = 3'd1; opa = 32'hDEAD; opb = 32'hBEEF; flush = 1'b0;
        tick;
        tick;
        check("stall_in_rst", 64'(stallreq), 64'd0);
        rst = 1'b0;
        op_valid = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stallreq), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'd0);
        check("rst_mul_ina", 64'(mul_ina), 64'd0);
        tick;

        run_long(3'd1, 32'hFFFFFFFE, 32'd3, n, ds);
        check("mult_stall_cycles", 64'(n), 64'd4);
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFFA);
        check("mult_done_state", 64'(dut.state_q), 64'd3);
        op_valid = 1'b0;
        tick;

        run_long(3'd2, 32'hFFFFFFFF, 32'd2, n, ds);
        check("multu_stall_cycles", 64'(n), 64'd4);
        check("multu_hi", 64'(hi), 64'd1);
        check("multu_lo", 64'(lo), 64'hFFFFFFFE);
        op_valid = 1'b0;
        tick;

        run_long(3'd3, 32'hFFFFFFF9, 32'd2, n, ds);
        check("div_stall_cycles", 64'(n), 64'd34);
        check("div_start_held", 64'(ds), 64'd33);
        check("div_hi", 64'(hi), 64'hFFFFFFFF);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_done_start", 64'(div_start), 64'd0);
        check("div_done_stall", 64'(stallreq), 64'd0);
        op_valid = 1'b0;
        tick;

        run_long(3'd3, 32'd5, 32'd0, n, ds);
`ifdef DIV_ZERO_FAST_EN
        check("div0_stall_cycles", 64'(n), 64'd1);
        check("div0_no_start", 64'(ds), 64'd0);
`else
        check("div0_stall_cycles", 64'(n), 64'd34);
        check("div0_started", 64'(ds), 64'd33);
`endif
        check("div0_hi", 64'(hi), 64'd5);
        check("div0_lo", 64'(lo), 64'hFFFFFFFF);
        op_valid = 1'b0;
        tick;

        op_valid = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd7;
        for (int i = 0; i < 11; i++) tick;
        check("flush_pre_start", 64'(div_start), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stallreq), 64'd0);
        tick;
        flush = 1'b0;
        op_valid = 1'b0;
        #1;
        check("flush_annul", 64'(div_annul), 64'd1);
        check("flush_state", 64'(dut.state_q), 64'd0);
        check("flush_div_start", 64'(div_start), 64'd0);
        check("flush_hi", 64'(hi), 64'd5);
        check("flush_lo", 64'(lo), 64'hFFFFFFFF);
        tick;
        check("flush_annul_pulse", 64'(div_annul), 64'd0);
        op_valid = 1'b1; op = 3'd5; opa = 32'h1234;
        #1;
        check("mthi_stall", 64'(stallreq), 64'd0);
        tick;
        op_valid = 1'b0;
        #1;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'hFFFFFFFF);

        tick;
        run_long(3'd1, 32'h00010000, 32'h00030000, n, ds);
        check("mult2_stall_cycles", 64'(n), 64'd4);
        tick;
        op = 3'd6; opa = 32'd7;
        #1;
        check("mtlo_state_idle", 64'(dut.state_q), 64'd0);
        check("mtlo_stall", 64'(stallreq), 64'd0);
        tick;
        op_valid = 1'b0;
        #1;
        check("mtlo_lo", 64'(lo), 64'd7);
        check("mtlo_hi", 64'(hi), 64'd3);
        check("mtlo_state", 64'(dut.state_q), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
